// File: rtl/fini_mul_pipe.sv
// Two-stage multi-channel FINI encoded multiplier: AND product per lane, codeword-set
// check on product and optionally operands, sticky alarm, saturating errored-beat counter.
module fini_mul_pipe #(
  parameter int unsigned            N            = 6,
  parameter int unsigned            CHANNELS     = 2,
  parameter logic [(1<<N)-1:0]      VALID_MASK   = 64'h8000_0000_0000_8009,
  parameter bit                     CHECK_INPUTS = 1'b1,
  parameter bit                     ZEROIZE      = 1'b1,
  parameter int unsigned            CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*N-1:0]     port_a,
  input  logic [CHANNELS*N-1:0]     port_b,
  input  logic                      alarm_clr,
  output logic                      out_valid,
  output logic [CHANNELS*N-1:0]     port_c,
  output logic [CHANNELS-1:0]       port_errorFlag,
  output logic                      alarm,
  output logic [CNT_W-1:0]          err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS*N-1:0] w_prod;
  logic [CHANNELS-1:0]   w_ierr;
  logic [CHANNELS-1:0]   w_err;
  logic [CHANNELS*N-1:0] w_c_nxt;
  logic                  w_beat_err;

  logic                  r_s1_vld;
  logic [CHANNELS*N-1:0] r_s1_prod;
  logic [CHANNELS-1:0]   r_s1_ierr;

  logic                  r_out_vld;
  logic [CHANNELS*N-1:0] r_port_c;
  logic [CHANNELS-1:0]   r_err_flag;
  logic                  r_alarm;
  logic [CNT_W-1:0]      r_err_cnt;

  // Per-lane datapath: each lane only ever sees its own operand slice.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_p1;

    assign w_a = port_a[k*N +: N];
    assign w_b = port_b[k*N +: N];
    assign w_prod[k*N +: N] = w_a & w_b;
    assign w_ierr[k] = CHECK_INPUTS & (~VALID_MASK[w_a] | ~VALID_MASK[w_b]);

    assign w_p1 = r_s1_prod[k*N +: N];
    assign w_err[k] = r_s1_ierr[k] | ~VALID_MASK[w_p1];
    assign w_c_nxt[k*N +: N] = (ZEROIZE && w_err[k]) ? '0 : w_p1;
  end

  assign w_beat_err = r_s1_vld & (|w_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_prod <= '0;
      r_s1_ierr <= '0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_prod <= w_prod;
        r_s1_ierr <= w_ierr;
      end
    end
  end

  // Idle beats present all-zero data so downstream never sees stale codewords.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_port_c   <= '0;
      r_err_flag <= '0;
    end else begin
      r_out_vld  <= r_s1_vld;
      r_port_c   <= r_s1_vld ? w_c_nxt : '0;
      r_err_flag <= r_s1_vld ? w_err : '0;
    end
  end

  // A fresh error beats a simultaneous clear so no fault is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm   <= 1'b0;
      r_err_cnt <= '0;
    end else if (alarm_clr) begin
      r_alarm   <= w_beat_err;
      r_err_cnt <= w_beat_err ? CNT_W'(1) : '0;
    end else if (w_beat_err) begin
      r_alarm <= 1'b1;
      if (r_err_cnt != CNT_MAX) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid      = r_out_vld;
  assign port_c         = r_port_c;
  assign port_errorFlag = r_err_flag;
  assign alarm          = r_alarm;
  assign err_count      = r_err_cnt;

endmodule

// File: tb/tb_fini_mul_pipe.sv
// Directed bench: three instances (default, no-zeroize/no-input-check, 2-bit counter) share stimulus.
module tb_fini_mul_pipe;
  localparam int N = 6;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CH*N-1:0] port_a, port_b;
  logic          alarm_clr;

  logic          ov0, ov1, ov2;
  logic [CH*N-1:0] c0, c1, c2;
  logic [CH-1:0] f0, f1, f2;
  logic          al0, al1, al2;
  logic [7:0]    cnt0, cnt1;
  logic [1:0]    cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fini_mul_pipe u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
    .alarm_clr(alarm_clr), .out_valid(ov0), .port_c(c0), .port_errorFlag(f0),
    .alarm(al0), .err_count(cnt0));

  fini_mul_pipe #(.CHECK_INPUTS(1'b0), .ZEROIZE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
    .alarm_clr(alarm_clr), .out_valid(ov1), .port_c(c1), .port_errorFlag(f1),
    .alarm(al1), .err_count(cnt1));

  fini_mul_pipe #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
    .alarm_clr(alarm_clr), .out_valid(ov2), .port_c(c2), .port_errorFlag(f2),
    .alarm(al2), .err_count(cnt2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [CH*N-1:0] a, input logic [CH*N-1:0] b);
    in_valid = 1'b1;
    port_a   = a;
    port_b   = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    port_a   = '0;
    port_b   = '0;
  endtask

  initial begin
    rst = 1'b1; alarm_clr = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rst_ov", ov0, 0);
    chk("rst_c", c0, 0);
    chk("rst_flag", f0, 0);
    chk("rst_alarm", al0, 0);
    chk("rst_cnt", cnt0, 0);

    // Clean beat: lane1 0F&0F, lane0 3F&03
    beat(12'h3FF, 12'h3C3);
    tick(); idle(); tick();
    chk("clean_ov", ov0, 1);
    chk("clean_c", c0, 12'h3C3);
    chk("clean_flag", f0, 2'b00);
    chk("clean_alarm", al0, 0);
    tick();
    chk("idle_ov", ov0, 0);
    chk("idle_c", c0, 0);

    // Fault: lane0 05&3F=05 (invalid), lane1 0F&03=03
    beat(12'h3C5, 12'h0FF);
    tick(); idle(); tick();
    chk("fault_flag", f0, 2'b01);
    chk("fault_c_zero", c0, 12'h0C0);
    chk("fault_alarm", al0, 1);
    chk("fault_cnt", cnt0, 1);
    chk("fault_flag_nz", f1, 2'b01);
    chk("fault_c_nz", c1, 12'h0C5);
    chk("fault_alarm_nz", al1, 1);

    // Operand check: lane0 07&03=03 valid product, 07 invalid operand
    beat(12'h007, 12'h003);
    tick(); idle(); tick();
    chk("inchk_flag", f0, 2'b01);
    chk("inchk_c", c0, 12'h000);
    chk("inchk_cnt", cnt0, 2);
    chk("noinchk_flag", f1, 2'b00);
    chk("noinchk_c", c1, 12'h003);
    chk("noinchk_cnt", cnt1, 1);

    // Standalone clear
    alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
    chk("clr_alarm", al0, 0);
    chk("clr_cnt", cnt0, 0);

    // Back-to-back clean/errored/clean, clear coincident with errored beat reaching stage 2
    beat(12'h3FF, 12'h3C3); tick();
    beat(12'h3C5, 12'h0FF); tick();
    chk("b2b_ov1", ov0, 1);
    chk("b2b_flag1", f0, 2'b00);
    beat(12'h3FF, 12'h3C3); alarm_clr = 1'b1; tick();
    alarm_clr = 1'b0; idle();
    chk("b2b_ov2", ov0, 1);
    chk("b2b_flag2", f0, 2'b01);
    chk("b2b_alarm", al0, 1);
    chk("b2b_cnt", cnt0, 1);
    chk("b2b_cnt_nz", cnt1, 1);
    tick();
    chk("b2b_ov3", ov0, 1);
    chk("b2b_flag3", f0, 2'b00);
    chk("b2b_c3", c0, 12'h3C3);
    chk("b2b_cnt_hold", cnt0, 1);
    tick();
    chk("b2b_ov4", ov0, 0);

    // Saturation on the 2-bit counter
    alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
    chk("sat_clr", cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      beat(12'h3C5, 12'h0FF);
      tick();
    end
    idle(); tick(); tick();
    chk("sat_cnt2", cnt2, 3);
    chk("sat_cnt0", cnt0, 5);
    tick();
    chk("sat_hold", cnt2, 3);

    // Reset with beats in flight
    beat(12'h3FF, 12'h3C3); tick();
    beat(12'h3C5, 12'h0FF); rst = 1'b1; tick();
    rst = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      chk("flush_ov", ov0, 0);
      chk("flush_c", c0, 0);
      tick();
    end
    chk("flush_flag", f0, 0);
    chk("flush_alarm", al0, 0);
    chk("flush_cnt", cnt0, 0);
    chk("flush_cnt2", cnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
